// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 5-stage MIPS core.
//
// Registers the decoded control bundles and operands from ID, resolves the
// write-back register, detects load-use hazards against the instruction held
// here, and inserts bubbles on hazard or flush. Holds on a global stall.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   stall_i             global stall: every register (and the counter) holds
//   flush_i             ID instruction is squashed (taken branch/jump)
//   id_*                decoded control, operands and specifiers from ID
//   ex_*                registered copies for EX; ex_wreg is the resolved
//                       destination, ex_valid is 0 for a bubble
//   load_use_o          combinational load-use hazard flag to the front end
//   bubble_cnt          saturating count of load-use bubbles
module id_ex_stage #(
    parameter int unsigned DW   = 32,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [1:0]      id_wb,
    input  logic [1:0]      id_m,
    input  logic [5:0]      id_ex,
    input  logic            id_shift,
    input  logic            id_jal,
    input  logic [DW-1:0]   id_rs_data,
    input  logic [DW-1:0]   id_rt_data,
    input  logic [DW-1:0]   id_imm,
    input  logic [DW-1:0]   id_pc4,
    input  logic [4:0]      id_rs,
    input  logic [4:0]      id_rt,
    input  logic [4:0]      id_rd,
    input  logic [4:0]      id_shamt,
    output logic [1:0]      ex_wb,
    output logic [1:0]      ex_m,
    output logic [5:0]      ex_ex,
    output logic            ex_shift,
    output logic            ex_jal,
    output logic [DW-1:0]   ex_rs_data,
    output logic [DW-1:0]   ex_rt_data,
    output logic [DW-1:0]   ex_imm,
    output logic [DW-1:0]   ex_pc4,
    output logic [4:0]      ex_rs,
    output logic [4:0]      ex_rt,
    output logic [4:0]      ex_shamt,
    output logic [4:0]      ex_wreg,
    output logic            ex_valid,
    output logic            load_use_o,
    output logic [CNTW-1:0] bubble_cnt
);

    logic [1:0]      wb_q, wb_d;
    logic [1:0]      m_q, m_d;
    logic [5:0]      ex_q, ex_d;
    logic            shift_q, shift_d;
    logic            jal_q, jal_d;
    logic [DW-1:0]   rs_data_q, rs_data_d;
    logic [DW-1:0]   rt_data_q, rt_data_d;
    logic [DW-1:0]   imm_q, imm_d;
    logic [DW-1:0]   pc4_q, pc4_d;
    logic [4:0]      rs_q, rs_d;
    logic [4:0]      rt_q, rt_d;
    logic [4:0]      shamt_q, shamt_d;
    logic [4:0]      wreg_q, wreg_d;
    logic            valid_q, valid_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic       load_use;
    logic [4:0] wreg_sel;

    // Both source fields are compared regardless of instruction format; the
    // occasional spurious stall is cheaper than decoding which fields are read.
    assign load_use = valid_q & m_q[1] & (rt_q != 5'd0) &
                      ((rt_q == id_rs) | (rt_q == id_rt));

    // Link writes $ra; otherwise RegDst picks rd (R-type) over rt (I-type).
    assign wreg_sel = id_jal ? 5'd31 : (id_ex[5] ? id_rd : id_rt);

    always_comb begin
        wb_d      = wb_q;
        m_d       = m_q;
        ex_d      = ex_q;
        shift_d   = shift_q;
        jal_d     = jal_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        pc4_d     = pc4_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        shamt_d   = shamt_q;
        wreg_d    = wreg_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;

        if (!stall_i) begin
            if (load_use || flush_i) begin
                // Bubble: all-zero so forwarding sees register 0 and no writes.
                wb_d      = '0;
                m_d       = '0;
                ex_d      = '0;
                shift_d   = 1'b0;
                jal_d     = 1'b0;
                rs_data_d = '0;
                rt_data_d = '0;
                imm_d     = '0;
                pc4_d     = '0;
                rs_d      = '0;
                rt_d      = '0;
                shamt_d   = '0;
                wreg_d    = '0;
                valid_d   = 1'b0;
                // Only load-use bubbles are counted, even when a flush coincides.
                if (load_use && (cnt_q != {CNTW{1'b1}})) begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end else begin
                wb_d      = id_wb;
                m_d       = id_m;
                ex_d      = id_ex;
                shift_d   = id_shift;
                jal_d     = id_jal;
                rs_data_d = id_rs_data;
                rt_data_d = id_rt_data;
                imm_d     = id_imm;
                pc4_d     = id_pc4;
                rs_d      = id_rs;
                rt_d      = id_rt;
                shamt_d   = id_shamt;
                wreg_d    = wreg_sel;
                valid_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q      <= '0;
            m_q       <= '0;
            ex_q      <= '0;
            shift_q   <= 1'b0;
            jal_q     <= 1'b0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            pc4_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            shamt_q   <= '0;
            wreg_q    <= '0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            wb_q      <= wb_d;
            m_q       <= m_d;
            ex_q      <= ex_d;
            shift_q   <= shift_d;
            jal_q     <= jal_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            pc4_q     <= pc4_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            shamt_q   <= shamt_d;
            wreg_q    <= wreg_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ex_wb      = wb_q;
    assign ex_m       = m_q;
    assign ex_ex      = ex_q;
    assign ex_shift   = shift_q;
    assign ex_jal     = jal_q;
    assign ex_rs_data = rs_data_q;
    assign ex_rt_data = rt_data_q;
    assign ex_imm     = imm_q;
    assign ex_pc4     = pc4_q;
    assign ex_rs      = rs_q;
    assign ex_rt      = rt_q;
    assign ex_shamt   = shamt_q;
    assign ex_wreg    = wreg_q;
    assign ex_valid   = valid_q;
    assign load_use_o = load_use;
    assign bubble_cnt = cnt_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 5-stage MIPS core. Registers the decoded control bundles (WB, M, EX) and operands from the ID stage, and resolves the write-back register address. Detects load-use hazards against the instruction it currently holds, and inserts bubbles on hazard or front-end flush. Holds its contents on a global stall, and keeps a saturating count of load-use bubbles for performance monitoring.

## Interface
- Parameters:
- `DW`, 32: datapath width (register data, immediate, PC+4).
- `CNTW`, 16: width of the load-use bubble counter.
- Ports (all `id_*` inputs come from the ID stage and the decoder; all `ex_*` outputs go to EX):
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `stall_i`, input, 1: global pipeline stall (e.g. memory wait); this stage holds.
- `flush_i`, input, 1: taken branch or jump resolved in ID; the ID instruction must not enter EX.
- `id_wb`, input, 2: {RegWrite, MemtoReg}.
- `id_m`, input, 2: {MemRead, MemWrite}.
- `id_ex`, input, 6: {RegDst, ALUSrc, ALUControl[3:0]}.
- `id_shift`, input, 1: shift instruction (ALU A operand is shamt).
- `id_jal`, input, 1: JAL or JALR link.
- `id_rs_data`, input, DW: rs read data.
- `id_rt_data`, input, DW: rt read data.
- `id_imm`, input, DW: sign-extended immediate.
- `id_pc4`, input, DW: PC+4 of the ID instruction.
- `id_rs`, `id_rt`, `id_rd`, input, 5 each: register specifiers.
- `id_shamt`, input, 5: shift amount.
- `ex_wb`, `ex_m`, `ex_ex`, `ex_shift`, `ex_rs_data`, `ex_rt_data`, `ex_imm`, `ex_pc4`, `ex_rs`, `ex_rt`, `ex_shamt`, output, same widths as the inputs: registered copies of the ID inputs.
- `ex_wreg`, output, 5: resolved destination register.
- `ex_valid`, output, 1: 1 when the stage holds a real instruction, 0 for a bubble.
- `load_use_o`, output, 1: combinational hazard flag; upstream holds PC and IF/ID while it is high.
- `bubble_cnt`, output, CNTW: count of load-use bubbles inserted.

## Operation
- Per-edge update, highest priority first:
  1. `stall_i`=1: all registers hold, and `bubble_cnt` holds.
  2. Else if `load_use_o` or `flush_i`: load a bubble.
  3. Else: capture all `id_*` inputs and set `ex_valid`=1.
- A bubble sets every output register to 0. In particular WB, M, EX, shift, jal, `ex_wreg`, `ex_rs`/`ex_rt` and `ex_valid` are all 0, so forwarding logic sees register 0.
- `ex_wreg` is registered from: 31 if `id_jal`; else `id_rd` if RegDst (`id_ex[5]`); else `id_rt`.
- `load_use_o` = `ex_valid` & `ex_m[1]` & (`ex_rt` ≠ 0) & (`ex_rt` == `id_rs` | `ex_rt` == `id_rt`).
  - Both source fields are compared unconditionally. Spurious stalls, e.g. for I-type instructions whose rt is a destination, are accepted.
- `load_use_o` depends only on registered state and the `id_*` specifiers. It is not gated by `stall_i` or `flush_i`.
- `bubble_cnt` increments by 1 on each edge where a bubble is loaded because `load_use_o`=1 and `stall_i`=0, including when `flush_i` is also high.
  - It saturates at all-ones; no wrap.
  - Bubbles caused only by `flush_i` are not counted.

## Timing
- Latency: one cycle, ID inputs to `ex_*` outputs.
- Reset (asynchronous assert, synchronous release by `clk`): every `ex_*` output is 0, `ex_valid`=0 and `bubble_cnt`=0.
  - `load_use_o` is therefore 0 during and immediately after reset.
  - Reset asserted mid-stall or mid-hazard clears the state immediately.
- Load-use sequence: LW in EX with a dependent instruction in ID raises `load_use_o` in that cycle. At the next edge a bubble enters EX while the dependent instruction is held upstream. In the following cycle `ex_valid`=0, so `load_use_o`=0 and the dependent instruction is captured at the next edge. Exactly one bubble per load-use pair.
- `stall_i` together with `load_use_o`: the stage holds and `load_use_o` stays high. The bubble is inserted on the first edge with `stall_i`=0.
- `flush_i` together with a hazard: one bubble is loaded and the counter increments once.
- `bubble_cnt` changes only on edges; it is never combinationally affected.

## Test plan
- Reset: drive `rst_n`=0 mid-cycle with non-zero contents -> all outputs 0 immediately; after release, `load_use_o`=0 and `bubble_cnt`=0.
- Pass-through: ADD with rs=8, rt=9, rd=10, RegDst=1, `id_rs_data`=0x5 -> next cycle `ex_wreg`=10, `ex_rs_data`=0x5, `ex_valid`=1. JAL -> `ex_wreg`=31. ADDI with rt=4 -> `ex_wreg`=4.
- Load-use: LW with rt=9 captured, then ID has rs=9 -> `load_use_o`=1. Next cycle `ex_valid`=0, `ex_m`=0 and `bubble_cnt`=1; the cycle after, the dependent instruction is captured.
- No hazard on $zero: LW with rt=0 followed by an instruction with rs=0 -> `load_use_o`=0 and no bubble.
- Stall priority: LW in EX with a hazard present and `stall_i`=1 for 3 cycles -> outputs unchanged, `load_use_o`=1 throughout, `bubble_cnt` unchanged. Then the bubble is inserted on the edge after `stall_i` falls.
- Flush and saturation: `flush_i`=1 with no hazard -> bubble, counter unchanged. With CNTW=4, force 17 load-use bubbles -> `bubble_cnt`=15.
